// File: rtl/ifetch_prefetch_pkg.sv
// Shared types and constants for the instruction fetch / prefetch slice.
package ifetch_prefetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Branch targets are word addresses; the low two bits are ignored.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Memory-side and core-side signals of the fetch stage, grouped in one bundle.
interface ifetch_prefetch_if;
  import ifetch_prefetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic [XLEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/ifetch_prefetch_fetch_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally on rdata_o.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and
// buffers returned words with their PCs for the core; redirects flush and refetch.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input logic               clk,
  input logic               rst,
  ifetch_prefetch_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   buf_count, pcq_count;
  logic            buf_full, buf_empty, pcq_full, pcq_empty;
  fetch_entry_t    buf_wdata, buf_rdata;
  logic [XLEN-1:0] pcq_rdata;

  logic req_c, issue, rsp, rsp_keep, pop, redirect;

  assign redirect = bus.redirect_valid;

  // Credits count buffered words plus in-flight fetches; a pop frees one only next cycle.
  assign req_c    = !rst && !redirect &&
                    ((SW'(buf_count) + SW'(outstanding_q)) < SW'(DEPTH));
  assign issue    = req_c && bus.imem_gnt;
  assign rsp      = bus.imem_rvalid && (outstanding_q != '0);
  assign rsp_keep = rsp && (drop_q == '0);
  assign pop      = !buf_empty && bus.instr_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);
    drop_d        = drop_q;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (rsp && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    // Every response still owed after this cycle belongs to the old path.
    if (redirect) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
      drop_d     = outstanding_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  assign buf_wdata = '{pc: pcq_rdata, instr: bus.imem_rdata};

  fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_prefetch_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_keep),
    .wdata_i (buf_wdata),
    .pop_i   (pop),
    .flush_i (redirect),
    .rdata_o (buf_rdata),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  // PCs of issued fetches, consumed in order as responses return (kept or dropped).
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_inflight_pcq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (issue),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp),
    .flush_i (1'b0),
    .rdata_o (pcq_rdata),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_count)
  );

  assign bus.imem_req    = req_c;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = !buf_empty;
  assign bus.instr_data  = buf_rdata.instr;
  assign bus.instr_pc    = buf_rdata.pc;

  a_rsp_expected:  assert property (@(posedge clk) disable iff (rst)
                                    bus.imem_rvalid |-> (outstanding_q != '0));
  a_pcq_tracks:    assert property (@(posedge clk) disable iff (rst) pcq_count == outstanding_q);
  a_pcq_no_ovf:    assert property (@(posedge clk) disable iff (rst) !(issue && pcq_full));
  a_pcq_no_udf:    assert property (@(posedge clk) disable iff (rst) !(rsp && pcq_empty));
  a_buf_no_ovf:    assert property (@(posedge clk) disable iff (rst)
                                    !(rsp_keep && buf_full && !pop && !redirect));
  a_drop_bounded:  assert property (@(posedge clk) disable iff (rst) drop_q <= outstanding_q);

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: in-order memory model plus expected-PC scoreboard.
module tb_ifetch_prefetch;
  import ifetch_prefetch_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ifetch_prefetch_if bus();

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          pops     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  bit          found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input bit cond);
    checks++;
    assert (cond) else begin
      failures++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  // Expected instruction stream from a given start PC.
  task automatic load_stream(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  // Drive one cycle's inputs, score any consumed instruction, record grants.
  task automatic apply(input logic gnt, input logic ready, input logic redir,
                       input logic [31:0] rpc);
    logic [31:0] e;
    bus.imem_gnt       = gnt;
    bus.instr_ready    = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = pend_addr.pop_front();
      void'(pend_due.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (bus.instr_valid && ready) begin
      check_true("sb_unexpected_instr", exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instr_pc", bus.instr_pc, e);
        check("instr_data", bus.instr_data, e);
        pops++;
      end
    end
    if (bus.imem_req && gnt) begin
      pend_addr.push_back(bus.imem_addr);
      pend_due.push_back(cyc + lat);
    end
    if (redir) load_stream({rpc[31:2], 2'b00});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst                = 1'b1;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   32'(bus.imem_req), 32'd0);
    check("rst_addr",  bus.imem_addr, RST_PC);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_data",  bus.instr_data, 32'd0);
    check("rst_pc",    bus.instr_pc, 32'd0);
    load_stream(RST_PC);
    rst = 1'b0;

    // Free-running fetch, 1-cycle memory returning address as data.
    pops = 0;
    repeat (20) begin apply(1, 1, 0, '0); tick(); end
    check_true("t1_progress", pops >= 6);

    // Core stalls: buffer fills to DEPTH, fetching stops, head holds.
    for (int i = 0; i < 10; i++) begin
      apply(1, 0, 0, '0);
      if (i >= 5) begin
        check("t2_valid", 32'(bus.instr_valid), 32'd1);
        check("t2_req",   32'(bus.imem_req), 32'd0);
        check("t2_head",  bus.instr_pc, exp_q[0]);
      end
      if (i == 9) check("t2_fetch_pc", bus.imem_addr, exp_q[0] + 32'(4 * DEPTH));
      tick();
    end
    pops = 0;
    repeat (10) begin apply(1, 1, 0, '0); tick(); end
    check_true("t2_resume", pops >= 4);

    // Grant withheld at 0x10: request and address held.
    apply(0, 1, 1, 32'h10);
    check("t3_redir_req", 32'(bus.imem_req), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, '0);
      check("t3_req",  32'(bus.imem_req), 32'd1);
      check("t3_addr", bus.imem_addr, 32'h10);
      tick();
    end
    pops = 0;
    repeat (12) begin apply(1, 1, 0, '0); tick(); end
    check_true("t3_resume", pops >= 4);

    // Redirect with two fetches in flight on a slower memory.
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend_addr.size() == 2) found = 1'b1;
      else begin apply(1, 1, 0, '0); tick(); end
    end
    check_true("t4_two_inflight", found);
    apply(1, 1, 1, 32'h103);
    check("t4_redir_req", 32'(bus.imem_req), 32'd0);
    tick();
    pops = 0;
    repeat (25) begin apply(1, 1, 0, '0); tick(); end
    check_true("t4_resume", pops >= 3);

    // Redirect colliding with rvalid and pop, then a second redirect.
    lat   = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend_addr.size() > 0 && pend_due[0] <= cyc && bus.instr_valid) found = 1'b1;
      else begin apply(1, 1, 0, '0); tick(); end
    end
    check_true("t5_collision_found", found);
    apply(1, 1, 1, 32'h180);
    check("t5_redir1_req", 32'(bus.imem_req), 32'd0);
    tick();
    apply(1, 1, 1, 32'h200);
    check("t5_flushed_valid", 32'(bus.instr_valid), 32'd0);
    check("t5_redir2_req", 32'(bus.imem_req), 32'd0);
    tick();
    pops = 0;
    repeat (12) begin apply(1, 1, 0, '0); tick(); end
    check_true("t5_resume", pops >= 3);

    // PC wraps past the top of the address space.
    apply(1, 1, 1, 32'hFFFF_FFFC);
    tick();
    apply(1, 1, 0, '0);
    check("t6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    check("t6_req_top",  32'(bus.imem_req), 32'd1);
    tick();
    apply(1, 1, 0, '0);
    check("t6_addr_wrap", bus.imem_addr, 32'h0);
    tick();
    repeat (8) begin apply(1, 1, 0, '0); tick(); end

    // Asynchronous reset mid-stream; memory forgets pre-reset requests.
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("t6_rst_addr",  bus.imem_addr, RST_PC);
    check("t6_rst_req",   32'(bus.imem_req), 32'd0);
    pend_addr.delete();
    pend_due.delete();
    bus.imem_rvalid = 1'b0;
    load_stream(RST_PC);
    tick();
    tick();
    rst  = 1'b0;
    pops = 0;
    repeat (12) begin apply(1, 1, 0, '0); tick(); end
    check_true("t6_restart", pops >= 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
